// File: rtl/pwl_wsum_pipe.sv
// pwl_wsum_pipe
//   Clocked N-channel weighted summer for piecewise-linear (pwl) signals.
//   Each pwl value is carried as three reals: a (offset at time t), b (slope
//   per second) and t (time in seconds).  On every sample edge the block forms
//     A = sum over enabled channels of scale[i] * eval(in[i], now)
//     B = sum over enabled channels of scale[i] * in[i].b
//   and emits {A + B*(now_emit - t_sample), B, now_emit} LAT edges later.
//   The emitted offset is re-projected to the emission time, so the output
//   stays continuous with the inputs delayed by LAT cycles.
//
//   Scale writes land in a shadow bank.  A commit copies the shadow bank into
//   the active bank atomically; the sample taken on the commit edge still
//   uses the old active bank.
//
//   Optional feature: define PWL_WSUM_CLAMP_EN to clamp the emitted offset to
//   [OUT_MIN, OUT_MAX].  A clamped output has zero slope, and the clamp_hit
//   port reports the clamp alongside out.
//
//   Time base: the module timeunit is 1 ns, and times are handled in seconds.
//
// Ports
//   clk, rst          rising-edge clock and synchronous active-high reset
//   in_a/in_b/in_t    pwl inputs, one entry per channel
//   ch_en             per-channel include mask
//   enable            1 = take a sample every edge, 0 = hold
//   cfg_valid/ready   scale-write handshake; ready is high outside IDLE
//   cfg_ch, cfg_scale target channel and value for a shadow write
//   cfg_commit        copy the shadow bank into the active bank
//   cfg_err           sticky flag for a write with cfg_ch >= NCH
//   out_a/out_b/out_t summed pwl output
//   out_valid         high once the first sample has emerged
//   clamp_hit         (PWL_WSUM_CLAMP_EN only) output was clamped
`timescale 1ns/1ps
module pwl_wsum_pipe #(
  parameter int  NCH        = 4,
  parameter int  LAT        = 1,
  parameter real SCALE_INIT = 1.0,
  parameter real OUT_MIN    = -1.0e3,
  parameter real OUT_MAX    = 1.0e3,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  real            in_a [NCH],
  input  real            in_b [NCH],
  input  real            in_t [NCH],
  input  logic [NCH-1:0] ch_en,
  input  logic           enable,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  real            cfg_scale,
  input  logic           cfg_commit,
  output logic           cfg_err,
  output real            out_a,
  output real            out_b,
  output real            out_t,
  output logic           out_valid
`ifdef PWL_WSUM_CLAMP_EN
  ,
  output logic           clamp_hit
`endif
);

  // Depth of the storage pipeline; LAT=0 keeps one unused stage so the
  // arrays are never zero-sized.
  localparam int PD = (LAT > 0) ? LAT : 1;
  localparam int LI = PD - 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t state_q, state_d;

  real scale_act [NCH];
  real scale_shd [NCH];

  real         a_p [PD];
  real         b_p [PD];
  real         t_p [PD];
  logic [PD-1:0] vld_p;

  logic take;

  function automatic real now_s();
    return $realtime * 1.0e-9;
  endfunction

  function automatic real sample_a(input real ts);
    real acc;
    acc = 0.0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_en[i]) acc += scale_act[i] * (in_a[i] + in_b[i] * (ts - in_t[i]));
    end
    return acc;
  endfunction

  function automatic real sample_b();
    real acc;
    acc = 0.0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_en[i]) acc += scale_act[i] * in_b[i];
    end
    return acc;
  endfunction

  // With LAT=0 the sample taken on this edge is emitted on the same edge.
  function automatic logic emit_vld();
    return (LAT == 0) ? take : vld_p[LI];
  endfunction

  function automatic real emit_b();
    return (LAT == 0) ? sample_b() : b_p[LI];
  endfunction

  function automatic real emit_a(input real tn);
    return (LAT == 0) ? sample_a(tn) : a_p[LI] + b_p[LI] * (tn - t_p[LI]);
  endfunction

  function automatic logic sat_hit(input real x);
    return (x > OUT_MAX) || (x < OUT_MIN);
  endfunction

  function automatic real sat(input real x);
    if (x > OUT_MAX) return OUT_MAX;
    if (x < OUT_MIN) return OUT_MIN;
    return x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (!enable) state_d = HOLD;
      HOLD:    if (enable)  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = (state_q != IDLE);

  // A HOLD edge with enable already back high samples immediately, so the
  // return to RUN leaves no gap in the output stream.
  assign take = (state_q != IDLE) && enable;

  // Configuration banks: writes go to the shadow bank; a commit folds in a
  // write made on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        scale_act[i] <= SCALE_INIT;
        scale_shd[i] <= SCALE_INIT;
      end
      cfg_err <= 1'b0;
    end else if (state_q != IDLE) begin
      if (cfg_valid) begin
        if (int'(cfg_ch) < NCH) scale_shd[cfg_ch] <= cfg_scale;
        else                    cfg_err <= 1'b1;
      end
      if (cfg_commit) begin
        for (int i = 0; i < NCH; i++) begin
          scale_act[i] <= (cfg_valid && int'(cfg_ch) == i) ? cfg_scale : scale_shd[i];
        end
      end
    end
  end

  // ---- stage 0: sample capture; stages 1..PD-1: plain delay ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= take;
      for (int i = 1; i < PD; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    a_p[0] <= sample_a(now_s());
    b_p[0] <= sample_b();
    t_p[0] <= now_s();
    for (int i = 1; i < PD; i++) begin
      a_p[i] <= a_p[i-1];
      b_p[i] <= b_p[i-1];
      t_p[i] <= t_p[i-1];
    end
  end

  // ---- emission: re-project the oldest sample to this edge ----
  // With no sample emerging, out keeps its last a/b/t so downstream
  // evaluation keeps extrapolating the same line.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a     <= 0.0;
      out_b     <= 0.0;
      out_t     <= now_s();
      out_valid <= 1'b0;
`ifdef PWL_WSUM_CLAMP_EN
      clamp_hit <= 1'b0;
`endif
    end else if (emit_vld()) begin
`ifdef PWL_WSUM_CLAMP_EN
      out_a     <= sat(emit_a(now_s()));
      out_b     <= sat_hit(emit_a(now_s())) ? 0.0 : emit_b();
      clamp_hit <= sat_hit(emit_a(now_s()));
`else
      out_a     <= emit_a(now_s());
      out_b     <= emit_b();
`endif
      out_t     <= now_s();
      out_valid <= 1'b1;
    end
  end

endmodule
